// File: rtl/profile_ci_sampler_pkg.sv
// Shared definitions for the profiling CI sampler: counter count, control
// word width, default CI identifier, sequencer state encodings and operand helpers.
package profile_ci_sampler_pkg;

  localparam int NUM_COUNTERS = 4;
  localparam int CTRL_WIDTH   = 12;

  localparam logic [7:0] DEFAULT_CUSTOM_ID = 8'h00;
  localparam logic [1:0] LAST_INDEX        = 2'd3;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_CTRL_ISSUE = 3'd1;
  localparam logic [2:0] ST_CTRL_WAIT  = 3'd2;
  localparam logic [2:0] ST_RD_ISSUE   = 3'd3;
  localparam logic [2:0] ST_RD_WAIT    = 3'd4;

  function automatic logic [31:0] selectWord(input logic [1:0] idx);
    return {30'd0, idx};
  endfunction

  function automatic logic [31:0] ctrlOperand(input logic [CTRL_WIDTH-1:0] word);
    return {{(32-CTRL_WIDTH){1'b0}}, word};
  endfunction

endpackage

// File: rtl/profile_ci_xact.sv
// One CI transaction: holds the operands, raises ciStart while the sequencer
// is issuing, and reports completion or timeout relative to the start cycle.
module profile_ci_xact
  import profile_ci_sampler_pkg::*;
#(
  parameter int TIMEOUT = 16
)(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic [1:0]            i_sel,
  input  logic [CTRL_WIDTH-1:0] i_ctrl,
  input  logic                  i_issue,
  input  logic                  i_wait,
  input  logic                  ciDone,
  output logic                  ciStart,
  output logic [31:0]           ciValueA,
  output logic [31:0]           ciValueB,
  output logic                  o_done,
  output logic                  o_timeout
);

  localparam int            CW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [31:0]   r_valueA;
  logic [31:0]   r_valueB;
  logic [CW-1:0] r_elapsed;
  logic          w_active;
  logic [CW-1:0] w_elapsed;

  // The start cycle counts as cycle zero, so done is accepted for TIMEOUT cycles.
  assign w_active  = i_issue | i_wait;
  assign w_elapsed = i_issue ? '0 : r_elapsed;

  assign ciStart   = i_issue;
  assign ciValueA  = r_valueA;
  assign ciValueB  = r_valueB;
  assign o_done    = w_active & ciDone;
  assign o_timeout = w_active & ~ciDone & (w_elapsed == LIMIT);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_valueA  <= '0;
      r_valueB  <= '0;
      r_elapsed <= '0;
    end else begin
      if (i_load) begin
        r_valueA <= selectWord(i_sel);
        r_valueB <= ctrlOperand(i_ctrl);
      end
      if (i_issue) begin
        r_elapsed <= CW'(1);
      end else if (i_wait) begin
        r_elapsed <= r_elapsed + CW'(1);
      end
    end
  end

endmodule

// File: rtl/profile_ci_sampler.sv
// Profiling CI initiator: issues counter-control CIs and four-read snapshots,
// committing snapshot data only when all four reads have completed.
module profile_ci_sampler
  import profile_ci_sampler_pkg::*;
#(
  parameter logic [7:0] CUSTOM_ID = DEFAULT_CUSTOM_ID,
  parameter int         TIMEOUT   = 16
)(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  writeCtrl,
  input  logic [CTRL_WIDTH-1:0] ctrlWord,
  input  logic                  startSnapshot,
  input  logic [1:0]            readIndex,
  output logic [31:0]           snapData,
  output logic                  snapValid,
  output logic                  snapDone,
  output logic                  busy,
  output logic                  reqDropped,
  output logic                  timeoutErr,
  output logic                  ciStart,
  output logic [7:0]            ciN,
  output logic [31:0]           ciValueA,
  output logic [31:0]           ciValueB,
  input  logic                  ciDone,
  input  logic [31:0]           ciResult
);

  logic [2:0]            r_state;
  logic                  r_pending;
  logic [1:0]            r_idx;
  logic                  r_snapValid;
  logic                  r_snapDone;
  logic                  r_reqDropped;
  logic                  r_timeoutErr;
  logic [31:0]           r_staging [NUM_COUNTERS];
  logic [31:0]           r_snap    [NUM_COUNTERS];

  logic [2:0]            w_nextState;
  logic                  w_idle;
  logic                  w_issue;
  logic                  w_wait;
  logic                  w_isRead;
  logic                  w_reqAny;
  logic                  w_done;
  logic                  w_timeout;
  logic                  w_load;
  logic [1:0]            w_loadSel;
  logic [CTRL_WIDTH-1:0] w_loadCtrl;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_issue  = (r_state == ST_CTRL_ISSUE) || (r_state == ST_RD_ISSUE);
  assign w_wait   = (r_state == ST_CTRL_WAIT)  || (r_state == ST_RD_WAIT);
  assign w_isRead = (r_state == ST_RD_ISSUE)   || (r_state == ST_RD_WAIT);
  assign w_reqAny = writeCtrl | startSnapshot;

  assign snapData   = r_snap[readIndex];
  assign snapValid  = r_snapValid;
  assign snapDone   = r_snapDone;
  assign busy       = ~w_idle;
  assign reqDropped = r_reqDropped;
  assign timeoutErr = r_timeoutErr;
  assign ciN        = CUSTOM_ID;

  profile_ci_xact #(.TIMEOUT(TIMEOUT)) u_xact (
    .clock     (clock),
    .reset     (reset),
    .i_load    (w_load),
    .i_sel     (w_loadSel),
    .i_ctrl    (w_loadCtrl),
    .i_issue   (w_issue),
    .i_wait    (w_wait),
    .ciDone    (ciDone),
    .ciStart   (ciStart),
    .ciValueA  (ciValueA),
    .ciValueB  (ciValueB),
    .o_done    (w_done),
    .o_timeout (w_timeout)
  );

  // Operands are loaded on the edge entering an ISSUE state so they are valid with ciStart.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_loadSel   = '0;
    w_loadCtrl  = '0;
    case (r_state)
      ST_IDLE: begin
        if (writeCtrl) begin
          w_nextState = ST_CTRL_ISSUE;
          w_load      = 1'b1;
          w_loadCtrl  = ctrlWord;
        end else if (startSnapshot) begin
          w_nextState = ST_RD_ISSUE;
          w_load      = 1'b1;
        end
      end
      ST_CTRL_ISSUE, ST_CTRL_WAIT: begin
        if (w_done) begin
          if (r_pending) begin
            w_nextState = ST_RD_ISSUE;
            w_load      = 1'b1;
          end else begin
            w_nextState = ST_IDLE;
          end
        end else if (w_timeout) begin
          w_nextState = ST_IDLE;
        end else begin
          w_nextState = ST_CTRL_WAIT;
        end
      end
      ST_RD_ISSUE, ST_RD_WAIT: begin
        if (w_done) begin
          if (r_idx == LAST_INDEX) begin
            w_nextState = ST_IDLE;
          end else begin
            w_nextState = ST_RD_ISSUE;
            w_load      = 1'b1;
            w_loadSel   = r_idx + 2'd1;
          end
        end else if (w_timeout) begin
          w_nextState = ST_IDLE;
        end else begin
          w_nextState = ST_RD_WAIT;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_pending    <= 1'b0;
      r_idx        <= '0;
      r_snapValid  <= 1'b0;
      r_snapDone   <= 1'b0;
      r_reqDropped <= 1'b0;
      r_timeoutErr <= 1'b0;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        r_staging[i] <= '0;
        r_snap[i]    <= '0;
      end
    end else begin
      r_state      <= w_nextState;
      r_snapDone   <= 1'b0;
      r_reqDropped <= ~w_idle & w_reqAny;
      if (w_idle && w_reqAny) begin
        r_timeoutErr <= 1'b0;
        r_pending    <= writeCtrl & startSnapshot;
        r_idx        <= '0;
      end
      if (w_done && !w_isRead) begin
        r_pending <= 1'b0;
      end
      // The last read bypasses staging so the commit sees all four words at once.
      if (w_done && w_isRead) begin
        r_staging[r_idx] <= ciResult;
        if (r_idx == LAST_INDEX) begin
          for (int i = 0; i < NUM_COUNTERS - 1; i++) begin
            r_snap[i] <= r_staging[i];
          end
          r_snap[NUM_COUNTERS-1] <= ciResult;
          r_snapValid <= 1'b1;
          r_snapDone  <= 1'b1;
        end else begin
          r_idx <= r_idx + 2'd1;
        end
      end
      if (w_timeout) begin
        r_timeoutErr <= 1'b1;
        r_pending    <= 1'b0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
          r_staging[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_profile_ci_sampler.sv
// Self-checking bench for profile_ci_sampler: responder model, CI/snapshot
// scoreboard checked by a monitor, and directed plus randomized requests.
module tb_profile_ci_sampler;

  localparam int         TIMEOUT   = 16;
  localparam logic [7:0] CUSTOM_ID = 8'hA5;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } ciExp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        writeCtrl;
  logic [11:0] ctrlWord;
  logic        startSnapshot;
  logic [1:0]  readIndex;
  logic [31:0] snapData;
  logic        snapValid;
  logic        snapDone;
  logic        busy;
  logic        reqDropped;
  logic        timeoutErr;
  logic        ciStart;
  logic [7:0]  ciN;
  logic [31:0] ciValueA;
  logic [31:0] ciValueB;
  logic        ciDone;
  logic [31:0] ciResult;

  logic [31:0] cnt [4];
  int          respLatency;
  int          respRemain;
  logic        respWaiting;
  logic        neverDone;

  ciExp_t      ciQ [$];
  logic [31:0] snapWordQ [$];
  int          expSnaps;
  int          snapCount;
  int          dropCount;
  int          passCount;
  int          totalCount;

  always #5 clock = ~clock;

  profile_ci_sampler #(.CUSTOM_ID(CUSTOM_ID), .TIMEOUT(TIMEOUT)) dut (
    .clock         (clock),
    .reset         (reset),
    .writeCtrl     (writeCtrl),
    .ctrlWord      (ctrlWord),
    .startSnapshot (startSnapshot),
    .readIndex     (readIndex),
    .snapData      (snapData),
    .snapValid     (snapValid),
    .snapDone      (snapDone),
    .busy          (busy),
    .reqDropped    (reqDropped),
    .timeoutErr    (timeoutErr),
    .ciStart       (ciStart),
    .ciN           (ciN),
    .ciValueA      (ciValueA),
    .ciValueB      (ciValueB),
    .ciDone        (ciDone),
    .ciResult      (ciResult)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic wc, input logic [11:0] cw, input logic ss);
    writeCtrl     = wc;
    ctrlWord      = cw;
    startSnapshot = ss;
    @(posedge clock); #1;
    writeCtrl     = 1'b0;
    startSnapshot = 1'b0;
  endtask

  task automatic expectCtrl(input logic [11:0] w);
    ciExp_t e;
    e.a = 32'd0;
    e.b = {20'd0, w};
    ciQ.push_back(e);
  endtask

  task automatic expectSnapshot();
    ciExp_t e;
    for (int i = 0; i < 4; i++) begin
      e.a = 32'(i);
      e.b = 32'd0;
      ciQ.push_back(e);
      snapWordQ.push_back(cnt[i]);
    end
    expSnaps++;
  endtask

  task automatic randomizeCounters();
    for (int i = 0; i < 4; i++) cnt[i] = $urandom;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  // Responder: completes respLatency cycles after ciStart and returns cnt[valueA].
  always @(negedge clock) begin
    if (!reset) begin
      respWaiting = 1'b0;
      ciDone      = 1'b0;
      ciResult    = $urandom;
    end else begin
      if (ciStart) begin
        respWaiting = 1'b1;
        respRemain  = respLatency;
      end
      if (respWaiting && !neverDone && respRemain == 0) begin
        ciDone      = 1'b1;
        ciResult    = cnt[ciValueA[1:0]];
        respWaiting = 1'b0;
      end else begin
        ciDone   = (!busy && !respWaiting) ? 1'($urandom_range(0, 1)) : 1'b0;
        ciResult = $urandom;
        if (respWaiting && respRemain > 0) respRemain--;
      end
    end
  end

  // Monitor: pops expected CI operands on ciStart and snapshot words on snapDone,
  // and holds snapData/snapValid to the last committed snapshot every cycle.
  initial begin : monitor
    logic        rstSeen;
    ciExp_t      e;
    logic [31:0] refSnap [4];
    logic        refValid;
    refValid  = 1'b0;
    readIndex = 2'd0;
    for (int i = 0; i < 4; i++) refSnap[i] = 32'd0;
    forever begin
      @(posedge clock);
      rstSeen = !reset;
      @(negedge clock);
      if (rstSeen) begin
        refValid = 1'b0;
        for (int i = 0; i < 4; i++) refSnap[i] = 32'd0;
      end
      if (reqDropped) dropCount++;
      if (snapDone) begin
        snapCount++;
        if (snapWordQ.size() >= 4) begin
          for (int i = 0; i < 4; i++) refSnap[i] = snapWordQ.pop_front();
          refValid = 1'b1;
        end else begin
          checkOutput("unexpected_snapDone", 32'd1, 32'd0);
        end
      end
      if (ciStart) begin
        if (ciQ.size() == 0) begin
          checkOutput("unexpected_ciStart", 32'd1, 32'd0);
        end else begin
          e = ciQ.pop_front();
          checkOutput("ciValueA", ciValueA, e.a);
          checkOutput("ciValueB", ciValueB, e.b);
          checkOutput("ciN", {24'd0, ciN}, {24'd0, CUSTOM_ID});
        end
      end
      checkOutput("snapValid", {31'd0, snapValid}, {31'd0, refValid});
      for (int i = 0; i < 4; i++) begin
        readIndex = 2'(i);
        #1;
        checkOutput($sformatf("snapData[%0d]", i), snapData, refSnap[i]);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [11:0] w;
    int          drops;
    int          op;
    reset         = 1'b0;
    writeCtrl     = 1'b0;
    ctrlWord      = 12'd0;
    startSnapshot = 1'b0;
    respLatency   = 0;
    respRemain    = 0;
    neverDone     = 1'b0;
    for (int i = 0; i < 4; i++) cnt[i] = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_busy",       {31'd0, busy},       32'd0);
    checkOutput("reset_ciStart",    {31'd0, ciStart},    32'd0);
    checkOutput("reset_ciValueA",   ciValueA,            32'd0);
    checkOutput("reset_ciValueB",   ciValueB,            32'd0);
    checkOutput("reset_ciN",        {24'd0, ciN},        {24'd0, CUSTOM_ID});
    checkOutput("reset_snapValid",  {31'd0, snapValid},  32'd0);
    checkOutput("reset_snapDone",   {31'd0, snapDone},   32'd0);
    checkOutput("reset_reqDropped", {31'd0, reqDropped}, 32'd0);
    checkOutput("reset_timeoutErr", {31'd0, timeoutErr}, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    $display("[TB] control write, zero-wait responder");
    respLatency = 0;
    expectCtrl(12'h00F);
    applyStimulus(1'b1, 12'h00F, 1'b0);
    checkOutput("ctrl_busy_first", {31'd0, busy},    32'd1);
    checkOutput("ctrl_ciStart",    {31'd0, ciStart}, 32'd1);
    @(posedge clock); #1;
    checkOutput("ctrl_busy_after", {31'd0, busy},    32'd0);

    $display("[TB] snapshot 10/20/30/40, done two cycles after start");
    cnt[0] = 32'd10; cnt[1] = 32'd20; cnt[2] = 32'd30; cnt[3] = 32'd40;
    respLatency = 2;
    expectSnapshot();
    applyStimulus(1'b0, 12'd0, 1'b1);
    waitIdle(100);
    @(posedge clock); #1;
    checkOutput("snap_count_basic", snapCount, expSnaps);

    $display("[TB] snapshot latency, zero-wait responder");
    randomizeCounters();
    respLatency = 0;
    expectSnapshot();
    applyStimulus(1'b0, 12'd0, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("lat_snapDone_N4", {31'd0, snapDone}, 32'd0);
    checkOutput("lat_busy_N4",     {31'd0, busy},     32'd1);
    @(posedge clock); #1;
    checkOutput("lat_snapDone_N5", {31'd0, snapDone}, 32'd1);
    checkOutput("lat_busy_N5",     {31'd0, busy},     32'd0);

    $display("[TB] control and snapshot in the same cycle");
    randomizeCounters();
    respLatency = 1;
    w = 12'($urandom_range(0, 4095));
    drops = dropCount;
    expectCtrl(w);
    expectSnapshot();
    applyStimulus(1'b1, w, 1'b1);
    waitIdle(200);
    @(posedge clock); #1;
    checkOutput("both_no_drop",    dropCount, drops);
    checkOutput("both_snap_count", snapCount, expSnaps);

    $display("[TB] randomized requests");
    for (int k = 0; k < 10; k++) begin
      op = $urandom_range(0, 2);
      respLatency = $urandom_range(0, 3);
      randomizeCounters();
      w = 12'($urandom_range(0, 4095));
      drops = dropCount;
      if (op != 1) expectCtrl(w);
      if (op != 0) expectSnapshot();
      applyStimulus(op != 1, w, op != 0);
      checkOutput("rand_busy", {31'd0, busy}, 32'd1);
      waitIdle(200);
      @(posedge clock); #1;
      checkOutput("rand_no_drop", dropCount, drops);
    end

    $display("[TB] timeout on a snapshot read");
    neverDone   = 1'b1;
    respLatency = 0;
    begin
      ciExp_t e;
      e.a = 32'd0;
      e.b = 32'd0;
      ciQ.push_back(e);
    end
    applyStimulus(1'b0, 12'd0, 1'b1);
    repeat (15) @(posedge clock);
    #1;
    checkOutput("to_busy_before",  {31'd0, busy},       32'd1);
    checkOutput("to_err_before",   {31'd0, timeoutErr}, 32'd0);
    @(posedge clock); #1;
    checkOutput("to_busy_after",   {31'd0, busy},       32'd0);
    checkOutput("to_err_after",    {31'd0, timeoutErr}, 32'd1);
    neverDone = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("to_err_sticky",   {31'd0, timeoutErr}, 32'd1);

    $display("[TB] request while busy");
    randomizeCounters();
    respLatency = 3;
    expectSnapshot();
    applyStimulus(1'b0, 12'd0, 1'b1);
    checkOutput("accept_clears_err", {31'd0, timeoutErr}, 32'd0);
    drops = dropCount;
    applyStimulus(1'b0, 12'd0, 1'b1);
    checkOutput("drop_pulse",      {31'd0, reqDropped}, 32'd1);
    @(posedge clock); #1;
    checkOutput("drop_pulse_end",  {31'd0, reqDropped}, 32'd0);
    waitIdle(200);
    @(posedge clock); #1;
    checkOutput("drop_count",      dropCount, drops + 1);
    checkOutput("drop_snap_count", snapCount, expSnaps);

    $display("[TB] reset during a read wait");
    randomizeCounters();
    respLatency = 3;
    begin
      ciExp_t e;
      e.a = 32'd0;
      e.b = 32'd0;
      ciQ.push_back(e);
    end
    applyStimulus(1'b0, 12'd0, 1'b1);
    @(posedge clock); #1;
    checkOutput("rst_mid_busy",     {31'd0, busy},       32'd1);
    reset = 1'b0;
    @(posedge clock); #1;
    checkOutput("rst_mid_busy0",    {31'd0, busy},       32'd0);
    checkOutput("rst_mid_ciStart",  {31'd0, ciStart},    32'd0);
    checkOutput("rst_mid_snapValid",{31'd0, snapValid},  32'd0);
    checkOutput("rst_mid_snapDone", {31'd0, snapDone},   32'd0);
    checkOutput("rst_mid_valueA",   ciValueA,            32'd0);
    checkOutput("rst_mid_valueB",   ciValueB,            32'd0);
    checkOutput("rst_mid_err",      {31'd0, timeoutErr}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    $display("[TB] snapshot after reset");
    randomizeCounters();
    respLatency = 0;
    expectSnapshot();
    applyStimulus(1'b0, 12'd0, 1'b1);
    waitIdle(100);
    repeat (2) @(posedge clock);
    #1;
    checkOutput("final_snap_count", snapCount, expSnaps);
    checkOutput("final_ciQ_empty",  ciQ.size(), 0);
    checkOutput("final_snapQ_empty", snapWordQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
